// File: rtl/game_controller.sv
// game_controller: top-level sequencer for the N-player column-drop game.
// Clears the board, hands each move to the validator, writes the accepted
// column, asks the logic unit for a win, and rotates or ends the game.
module game_controller #(
  parameter int COLS    = 7,
  parameter int ROWS    = 6,
  parameter int PLAYERS = 2,
  localparam int AW  = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int PW  = (PLAYERS > 2) ? $clog2(PLAYERS) : 1,
  localparam int MCW = $clog2(COLS*ROWS+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               play,
  input  logic               move_valid,
  input  logic [AW-1:0]      move_col,
  input  logic               val_done,
  input  logic               val_ok,
  input  logic [ROWS-1:0]    val_onoff,
  input  logic [ROWS*PW-1:0] val_player,
  input  logic               chk_done,
  input  logic               chk_win,
  output logic               val_go,
  output logic               chk_go,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [ROWS-1:0]    mem_onoff,
  output logic [ROWS*PW-1:0] mem_player,
  output logic [PW-1:0]      cur_player,
  output logic [MCW-1:0]     move_count,
  output logic               game_over,
  output logic               draw,
  output logic [PW-1:0]      winner,
  output logic               reject,
  output logic               busy
);

  localparam logic [MCW-1:0] MAX_MOVES   = MCW'(COLS*ROWS);
  localparam logic [AW-1:0]  LAST_COL    = AW'(COLS-1);
  localparam logic [PW-1:0]  LAST_PLAYER = PW'(PLAYERS-1);

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_VALIDATE, S_WRITE, S_CHECK, S_OVER
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        clr_cnt_q, clr_cnt_d;
  logic [AW-1:0]        col_q, col_d;
  logic [ROWS-1:0]      onoff_q, onoff_d;
  logic [ROWS*PW-1:0]   player_q, player_d;
  logic [PW-1:0]        cur_player_q, cur_player_d;
  logic [MCW-1:0]       move_count_q, move_count_d;
  logic                 game_over_q, game_over_d;
  logic                 draw_q, draw_d;
  logic [PW-1:0]        winner_q, winner_d;
  logic                 reject_q, reject_d;

  logic                 we_c, val_go_c, chk_go_c, busy_c;
  logic [AW-1:0]        addr_c;
  logic [ROWS-1:0]      onoff_c;
  logic [ROWS*PW-1:0]   player_c;

  // State and datapath registers; reset restarts the clear sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_CLEAR;
      clr_cnt_q    <= '0;
      col_q        <= '0;
      onoff_q      <= '0;
      player_q     <= '0;
      cur_player_q <= '0;
      move_count_q <= '0;
      game_over_q  <= 1'b0;
      draw_q       <= 1'b0;
      winner_q     <= '0;
      reject_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      col_q        <= col_d;
      onoff_q      <= onoff_d;
      player_q     <= player_d;
      cur_player_q <= cur_player_d;
      move_count_q <= move_count_d;
      game_over_q  <= game_over_d;
      draw_q       <= draw_d;
      winner_q     <= winner_d;
      reject_q     <= reject_d;
    end
  end

  // Next-state, datapath updates and Moore outputs per state.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    col_d        = col_q;
    onoff_d      = onoff_q;
    player_d     = player_q;
    cur_player_d = cur_player_q;
    move_count_d = move_count_q;
    game_over_d  = game_over_q;
    draw_d       = draw_q;
    winner_d     = winner_q;
    reject_d     = 1'b0;
    we_c         = 1'b0;
    addr_c       = '0;
    onoff_c      = '0;
    player_c     = '0;
    val_go_c     = 1'b0;
    chk_go_c     = 1'b0;
    busy_c       = 1'b1;

    case (state_q)
      S_CLEAR: begin
        we_c   = 1'b1;
        addr_c = clr_cnt_q;
        if (clr_cnt_q == LAST_COL) begin
          clr_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        busy_c = 1'b0;
        if (play && move_valid) begin
          col_d   = move_col;
          state_d = S_VALIDATE;
        end
      end
      S_VALIDATE: begin
        val_go_c = 1'b1;
        addr_c   = col_q;
        if (val_done) begin
          if (val_ok) begin
            onoff_d  = val_onoff;
            player_d = val_player;
            state_d  = S_WRITE;
          end else begin
            reject_d = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        we_c     = 1'b1;
        addr_c   = col_q;
        onoff_c  = onoff_q;
        player_c = player_q;
        if (move_count_q != MAX_MOVES) move_count_d = move_count_q + 1'b1;
        state_d  = S_CHECK;
      end
      S_CHECK: begin
        chk_go_c = 1'b1;
        addr_c   = col_q;
        if (chk_done) begin
          if (chk_win) begin
            game_over_d = 1'b1;
            winner_d    = cur_player_q;
            state_d     = S_OVER;
          end else if (move_count_q == MAX_MOVES) begin
            game_over_d = 1'b1;
            draw_d      = 1'b1;
            state_d     = S_OVER;
          end else begin
            cur_player_d = (cur_player_q == LAST_PLAYER) ? '0 : cur_player_q + 1'b1;
            state_d      = S_IDLE;
          end
        end
      end
      S_OVER: begin
        busy_c = 1'b0;
        if (play) begin
          state_d      = S_CLEAR;
          clr_cnt_d    = '0;
          cur_player_d = '0;
          move_count_d = '0;
          game_over_d  = 1'b0;
          draw_d       = 1'b0;
          winner_d     = '0;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Every output is held low for as long as reset is asserted.
  assign mem_we     = we_c & ~reset;
  assign mem_addr   = reset ? '0 : addr_c;
  assign mem_onoff  = reset ? '0 : onoff_c;
  assign mem_player = reset ? '0 : player_c;
  assign val_go     = val_go_c & ~reset;
  assign chk_go     = chk_go_c & ~reset;
  assign busy       = busy_c & ~reset;
  assign cur_player = reset ? '0 : cur_player_q;
  assign move_count = reset ? '0 : move_count_q;
  assign game_over  = game_over_q & ~reset;
  assign draw       = draw_q & ~reset;
  assign winner     = reset ? '0 : winner_q;
  assign reject     = reject_q & ~reset;

endmodule
